// File: rtl/des_sbox_iter.sv
// des_sbox_iter
//   Iterative DES S-box substitution. A 48-bit word B1..B8 is captured on
//   acceptance, then PAR S-boxes are evaluated per cycle over STEPS = 8/PAR
//   cycles. The 32-bit result {S1(B1),...,S8(B8)} is held until consumed.
//   Timing never depends on the data value.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   in48 carries a word to substitute
//   in_ready   block can accept a word (IDLE only)
//   in48       B1 = in48[47:42] .. B8 = in48[5:0]
//   out_valid  out32 holds a completed result (DONE only)
//   out_ready  consumer accepts out32
//   out32      S1 result in out32[31:28] .. S8 in out32[3:0]
//   busy       high while substituting (RUN only)
//
// state | meaning
// IDLE  | waiting for a word; out32 keeps the previous result
// RUN   | evaluating PAR S-boxes per cycle, step cnt
// DONE  | result valid, waiting for out_ready
module des_sbox_iter #(
    parameter int PAR = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in48,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out32,
    output logic        busy
);

    localparam int STEPS = 8 / PAR;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (!(PAR == 1 || PAR == 2 || PAR == 4 || PAR == 8)) begin : g_par_check
            $fatal(1, "des_sbox_iter: PAR must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [47:0]     din_q;
    logic [31:0]     out_q;
    logic [3:0]      s_res [PAR];

    // Tables are stored row-major, entry (row*16 + col) at the most
    // significant end, so a 6-bit input b maps to index {b5,b0,b4..b1}.
    function automatic logic [3:0] sbox(input logic [2:0] box, input logic [5:0] b);
        logic [255:0] tbl;
        logic [5:0]   idx;
        idx = {b[5], b[0], b[4:1]};
        case (box)
            3'd0: tbl = {64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
                         64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D};
            3'd1: tbl = {64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
                         64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9};
            3'd2: tbl = {64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
                         64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C};
            3'd3: tbl = {64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
                         64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E};
            3'd4: tbl = {64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
                         64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453};
            3'd5: tbl = {64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
                         64'h9EF528C3704A1DB6, 64'h432C95FABE17608D};
            3'd6: tbl = {64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
                         64'h14BDC37EAF680592, 64'h6BD814A7950FE23C};
            default: tbl = {64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
                            64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};
        endcase
        return tbl[255 - 4*int'(idx) -: 4];
    endfunction

    // Lane j serves boxes j, PAR+j, 2*PAR+j, ... on successive steps.
    always_comb begin
        for (int j = 0; j < PAR; j++) begin
            s_res[j] = sbox(3'(int'(cnt_q) * PAR + j),
                            din_q[47 - 6*(int'(cnt_q) * PAR + j) -: 6]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_q == CW'(STEPS - 1)) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q <= '0;
            cnt_q <= '0;
            out_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        din_q <= in48;
                        out_q <= '0;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    for (int k = 0; k < 8; k++) begin
                        if (k / PAR == int'(cnt_q)) begin
                            out_q[31 - 4*k -: 4] <= s_res[k % PAR];
                        end
                    end
                    // Saturate at the last step; only acceptance restarts cnt.
                    if (cnt_q != CW'(STEPS - 1)) cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out32 = out_q;

endmodule
